// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if: user-side request/response bundle for sram_ctrl.
//   req    request strobe, taken only while ready=1
//   wr     1 = write, 0 = read (qualified by req)
//   addr   request address (qualified by req)
//   wdata  write data (qualified by req)
//   ready  controller idle, may accept req this cycle
//   rdata  last read result, held until the next read completes
//   rvalid one-cycle pulse when rdata has been updated
// Modports: master = user logic, slave = controller.
interface sram_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              req;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;

  modport master (
    output req, wr, addr, wdata,
    input  ready, rdata, rvalid
  );

  modport slave (
    input  req, wr, addr, wdata,
    output ready, rdata, rvalid
  );
endinterface

// File: rtl/sram_ctrl.sv
// sram_ctrl: synchronous initiator for an external asynchronous SRAM with
// active-low oe_n/we_n and a shared data bus (write commits on we_n fall).
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        asynchronous active-high reset
//   bus        user handshake (sram_ctrl_if.slave)
//   sram_addr  SRAM address, holds its last value while idle
//   sram_data  SRAM data bus, driven only in the write states
//   sram_oe_n  SRAM output enable, active low
//   sram_we_n  SRAM write enable, active low
// Every pin-facing output is a register decoded from the next state, so the
// pins change cleanly on the clock edge that enters each state.
module sram_ctrl #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 8,
  parameter int WE_CYCLES = 2,
  parameter int RD_WAIT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  sram_ctrl_if.slave        bus,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam int CNT_MAX = (WE_CYCLES > RD_WAIT) ? WE_CYCLES : RD_WAIT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_RD_WAIT,
    S_RD_TURN
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [DATA_W-1:0]  wdata_reg;
  logic [DATA_W-1:0]  rdata_reg;
  logic               ready_reg;
  logic               rvalid_reg;
  logic               drive_reg;
  logic               accept;
  logic               capture;

  // Next-state logic. The counter holds "remaining cycles minus one" and is
  // reloaded whenever a timed state is entered.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (bus.req) begin
          accept = 1'b1;
          if (bus.wr) begin
            state_next = S_WR_SETUP;
            cnt_next   = '0;
          end else begin
            state_next = S_RD_WAIT;
            cnt_next   = CNT_W'(RD_WAIT - 1);
          end
        end
      end
      S_WR_SETUP: begin
        state_next = S_WR_PULSE;
        cnt_next   = CNT_W'(WE_CYCLES - 1);
      end
      S_WR_PULSE: begin
        if (cnt_reg == '0) begin
          state_next = S_WR_HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      S_WR_HOLD: begin
        state_next = S_IDLE;
      end
      S_RD_WAIT: begin
        // Last cycle with oe_n low: the SRAM output is valid, sample it now.
        if (cnt_reg == '0) begin
          capture    = 1'b1;
          state_next = S_RD_TURN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      S_RD_TURN: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
      ready_reg  <= 1'b1;
      rvalid_reg <= 1'b0;
      drive_reg  <= 1'b0;
      sram_addr  <= '0;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      ready_reg  <= (state_next == S_IDLE);
      rvalid_reg <= capture;
      // oe_n only in read states and drive only in write states, so the
      // two can never overlap on the bus.
      sram_oe_n  <= (state_next != S_RD_WAIT);
      sram_we_n  <= (state_next != S_WR_PULSE);
      drive_reg  <= (state_next == S_WR_SETUP) ||
                    (state_next == S_WR_PULSE) ||
                    (state_next == S_WR_HOLD);
      if (capture) begin
        rdata_reg <= sram_data;
      end
      if (accept) begin
        sram_addr <= bus.addr;
        wdata_reg <= bus.wdata;
      end
    end
  end

  assign sram_data  = drive_reg ? wdata_reg : {DATA_W{1'bz}};
  assign bus.ready  = ready_reg;
  assign bus.rvalid = rvalid_reg;
  assign bus.rdata  = rdata_reg;

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Synchronous initiator for the external asynchronous 1K x 8 SRAM (active-low output and write enables, shared bidirectional data bus, write committed on the falling edge of write-enable). It accepts single-beat read and write requests from on-chip logic through a ready/request handshake. It generates the SRAM address, data, oe_n and we_n sequences with fixed, parameterised setup, pulse and turnaround timing. It sits between the user logic and the SRAM pins or the SRAM behavioural model in the test environment.

## Interface
- ADDR_W, 10, SRAM address width
- DATA_W, 8, SRAM data width
- WE_CYCLES, 2, clock cycles sram_we_n is held low per write (>= 1)
- RD_WAIT, 2, clock cycles sram_oe_n is held low before read data is sampled (>= 1)

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  1  request strobe, accepted only when ready=1
- wr  in  1  1 = write, 0 = read, sampled with req
- addr  in  ADDR_W  request address, sampled with req
- wdata  in  DATA_W  write data, sampled with req
- ready  out  1  controller idle, can accept req this cycle
- rdata  out  DATA_W  read result, held until next read completes
- rvalid  out  1  one-cycle pulse, rdata updated
- sram_addr  out  ADDR_W  SRAM address
- sram_data  inout  DATA_W  SRAM data bus, driven only during write states, else high-Z
- sram_oe_n  out  1  SRAM output enable, active low
- sram_we_n  out  1  SRAM write enable, active low

## Operation
- All outputs are registered; the sram_data drive enable is a registered flag.
- FSM states: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_WAIT, RD_TURN.
- IDLE: ready=1, oe_n=1, we_n=1, bus high-Z. On req=1, addr, wr and wdata are latched and sram_addr is loaded.
  - wr=1 -> WR_SETUP
  - wr=0 -> RD_WAIT
- WR_SETUP, 1 cycle: sram_data driven with latched wdata, we_n=1. Address and data are stable before the we_n falling edge.
- WR_PULSE, WE_CYCLES cycles: we_n=0, data and address held.
- WR_HOLD, 1 cycle: we_n=1, data still driven. Then -> IDLE, drive released.
- RD_WAIT, RD_WAIT cycles: oe_n=0, bus high-Z. On the last edge:
  - sram_data is captured into rdata and rvalid=1 for one cycle
  - oe_n returns to 1
  - -> RD_TURN
- RD_TURN, 1 cycle bus turnaround: ready=0, then -> IDLE.
- Cycle counter is sized for max(WE_CYCLES, RD_WAIT) and reloads on every state entry.
- sram_oe_n=0 and sram_data drive are never active in the same cycle. sram_we_n and sram_oe_n are never both low.
- req while ready=0 is ignored, not queued. sram_addr holds its last value in IDLE.

## Timing
- Reset values: ready=1, rvalid=0, rdata=0, sram_addr=0, sram_oe_n=1, sram_we_n=1, sram_data high-Z, state IDLE.
- Write: ready low for WE_CYCLES+2 cycles (4 by default). we_n falls one cycle after acceptance. The SRAM commits at that edge.
- Read: rvalid asserts RD_WAIT cycles after acceptance (2 by default). ready low for RD_WAIT+1 cycles (3 by default).
- Back-to-back: req held high issues the next access on the first cycle ready=1. Throughput:
  - writes: one per WE_CYCLES+3 cycles
  - reads: one per RD_WAIT+2 cycles
- Reset mid-operation: all outputs return to reset values immediately, asynchronously.
  - Reset in WR_SETUP: no write occurs.
  - Reset in WR_PULSE or WR_HOLD: the write has already committed.
  - Reset in RD_WAIT: no rvalid, rdata keeps its prior value (0 after reset).

## Test plan
- Reset, then write 0xA5 to addr 0x155 -> we_n low exactly 2 cycles, data stable from one cycle before we_n falls until one cycle after we_n rises; model location 0x155 = 0xA5.
- Read addr 0x155 -> oe_n low 2 cycles, rvalid one pulse 2 cycles after acceptance with rdata=0xA5, ready high again 3 cycles after acceptance.
- Write 0x00 @0x000, 0xFF @0x3FF, then read both -> rdata 0x00, 0xFF (address extremes, data extremes).
- Write @0x010 immediately followed by read @0x010 with req held high -> read accepted on the first ready cycle, returns written value, no cycle with oe_n=0 and bus driven.
- Assert req while ready=0 during a write -> request dropped, only one SRAM access observed.
- Assert rst during WR_SETUP of write 0x3C @0x020 (location previously 0x11) -> outputs at reset values that cycle, location still 0x11; re-run with rst in WR_PULSE -> location 0x3C.
